core_wb: RTL and testbench
==========================

Name: core_wb

Overview:
- Write-back stage of the 5-stage RISC-V core. Sits directly downstream of the memory-access stage and consumes its mw_* bundle.
- Holds one retiring instruction in a single-entry register. Aligns and sign/zero-extends load data, then writes the integer register file and the CSR file.
- Provides a forwarding source for earlier stages and maintains the retired-instruction counter.

Parameters:
- INSTRET_W, 64, width of retired-instruction counter
- XLEN, 32, datapath width

Ports:
- clk  input  1  stage clock
- rest  input  1  synchronous active-high reset
- mw_valid  input  1  upstream entry valid
- mw_ready  output  1  stage can accept an entry this cycle
- mw_reg_data  input  XLEN  ALU result / load address
- mw_mem_data  input  XLEN  raw 32-bit word read from memory
- mw_csr_data  input  XLEN  value to write to CSR
- mw_rd  input  5  destination register
- mw_reg_write  input  1  instruction writes rd
- mw_reg_write_sel  input  1  0: rd <= reg_data; 1: rd <= aligned load data
- mw_mem_op  input  3  load funct3 (LB/LH/LW/LBU/LHU)
- mw_csr  input  12  CSR address
- mw_csr_write  input  1  instruction writes CSR
- rf_we  output  1  register file write enable
- rf_waddr  output  5  register file write address
- rf_wdata  output  XLEN  register file write data
- csr_we  output  1  CSR write request
- csr_waddr  output  12  CSR address
- csr_wdata  output  XLEN  CSR write data
- csr_wready  input  1  CSR file accepts write this cycle
- fwd_valid  output  1  forwarding entry valid (held entry writes a nonzero rd)
- fwd_rd  output  5  forwarded rd
- fwd_data  output  XLEN  forwarded value (final rf_wdata)
- instret  output  INSTRET_W  retired-instruction count

Behaviour:
- Single clock, synchronous active-high reset on rest. Reset clears the following:
  - wb_valid=0, so rf_we=0, csr_we=0 and fwd_valid=0
  - all held fields=0, so rf_waddr/rf_wdata/csr_waddr/csr_wdata/fwd_rd/fwd_data=0
  - instret=0
  - mw_ready=1 in the first cycle after reset
- States:
  - EMPTY (wb_valid=0)
  - HOLD (wb_valid=1)
- Retire condition: retire = wb_valid && (!held_csr_write || csr_wready).
- Ready: mw_ready = !wb_valid || retire. This is combinational from csr_wready; it has no dependency on mw_valid.
- Capture on mw_valid && mw_ready.
  - Register all mw_* fields.
  - Go to HOLD, or stay in HOLD if retire and capture happen in the same cycle; the new entry overwrites the retired one.
  - Latency: 1 cycle from capture to rf_we/csr_we.
- Leave HOLD for EMPTY on retire without a simultaneous capture.
- rf_we = wb_valid && held_reg_write && held_rd!=0 && retire. It is asserted exactly once per instruction, in the retire cycle. rd=x0 is never written.
- csr_we = wb_valid && held_csr_write.
  - Held high until csr_wready.
  - csr_waddr and csr_wdata are stable while stalled.
- A stall on csr_wready=0 deasserts mw_ready and holds the entry. rf_we stays low until the cycle in which the CSR write completes, so both writes occur in the same cycle.
- Load alignment (when held_reg_write_sel=1). The byte offset is held_reg_data[1:0].
  - LB/LBU: byte at offset*8, sign-extended / zero-extended
  - LH/LHU: halfword at held_reg_data[1]*16, sign-extended / zero-extended; offset[0] is ignored
  - LW and reserved codes (011, 110, 111): full word
  - Misaligned accesses are not detected here.
- rf_wdata = held_reg_write_sel ? aligned_load : held_reg_data.
- Forwarding:
  - fwd_valid = wb_valid && held_reg_write && held_rd!=0, independent of the CSR stall.
  - fwd_data = rf_wdata.
- instret increments by 1 on every retire and wraps modulo 2^INSTRET_W.
- Reset mid-stall: the entry is dropped and csr_we drops in the following cycle; no write is issued.

Decomposition:
- Shared package core_pkg:
  - load funct3 constants LOAD_LB=3'b000, LOAD_LH=3'b001, LOAD_LW=3'b010, LOAD_LBU=3'b100, LOAD_LHU=3'b101
  - the wb entry struct typedef (rd, reg_data, mem_data, csr_data, csr, mem_op, flags)
- One combinational sub-module, core_wb_load_align:
  - inputs: word, offset[1:0], mem_op
  - output: XLEN result

Test Plan:
- ALU writeback: mw_valid=1, reg_write=1, sel=0, rd=5, reg_data=0x1234_5678 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234_5678; instret 0->1.
- Loads, mem_data=0x80FF_7F01:
  - LB at addr offset 3 -> 0xFFFF_FF80
  - LBU at offset 2 -> 0x0000_00FF
  - LH at offset 2 -> 0xFFFF_80FF
  - LHU at offset 0 -> 0x0000_7F01
  - LW -> 0x80FF_7F01
- x0 suppression: reg_write=1, rd=0 -> rf_we=0, fwd_valid=0; instret still increments.
- CSR stall: csr_write=1, csr=0x300, csr_data=0x8, reg_write=1 rd=7, csr_wready low 3 cycles -> the following all hold for 3 cycles:
  - csr_we=1 with stable addr/data
  - mw_ready=0, rf_we=0
  - fwd_valid=1
  - On csr_wready=1: rf_we and csr_we fire together and mw_ready=1.
- Back-to-back: mw_valid held high for 4 entries with csr_wready=1 -> one retire per cycle, mw_ready constantly 1, instret +4.
- Reset during a CSR stall -> next cycle csr_we=0, fwd_valid=0, instret=0, mw_ready=1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and constants for the core pipeline: load funct3 encodings and
// the write-back entry that the WB stage holds for one retiring instruction.
package core_pkg;

  localparam int XLEN_PKG = 32;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;

  typedef struct packed {
    logic reg_write;
    logic reg_write_sel;
    logic csr_write;
  } wb_flags_t;

  typedef struct packed {
    logic [4:0]          rd;
    logic [XLEN_PKG-1:0] reg_data;
    logic [XLEN_PKG-1:0] mem_data;
    logic [XLEN_PKG-1:0] csr_data;
    logic [11:0]         csr;
    logic [2:0]          mem_op;
    wb_flags_t           flags;
  } wb_entry_t;

endpackage

// File: rtl/core_wb_load_align.sv
// Picks the addressed byte/halfword out of a raw memory word and extends it
// according to the load funct3; reserved encodings pass the whole word.
module core_wb_load_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      mem_op,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // The halfword lane only looks at offset[1]; misalignment is not flagged here.
  assign byte_sel = word[{offset, 3'b000} +: 8];
  assign half_sel = word[{offset[1], 4'b0000} +: 16];

  always_comb begin
    result = word;
    case (mem_op)
      LOAD_LB:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LOAD_LBU: result = {{(XLEN-8){1'b0}}, byte_sel};
      LOAD_LH:  result = {{(XLEN-16){half_sel[15]}}, half_sel};
      LOAD_LHU: result = {{(XLEN-16){1'b0}}, half_sel};
      default:  result = word;
    endcase
  end

endmodule

// File: rtl/core_wb.sv
// Write-back stage: holds one retiring instruction, writes the register file
// and CSR file together, forwards the result and counts retired instructions.
module core_wb
  import core_pkg::*;
#(
  parameter int INSTRET_W = 64,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rest,
  input  logic                 mw_valid,
  output logic                 mw_ready,
  input  logic [XLEN-1:0]      mw_reg_data,
  input  logic [XLEN-1:0]      mw_mem_data,
  input  logic [XLEN-1:0]      mw_csr_data,
  input  logic [4:0]           mw_rd,
  input  logic                 mw_reg_write,
  input  logic                 mw_reg_write_sel,
  input  logic [2:0]           mw_mem_op,
  input  logic [11:0]          mw_csr,
  input  logic                 mw_csr_write,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 csr_we,
  output logic [11:0]          csr_waddr,
  output logic [XLEN-1:0]      csr_wdata,
  input  logic                 csr_wready,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [XLEN-1:0]      fwd_data,
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [0:0] STATE_EMPTY = 1'b0;
  localparam logic [0:0] STATE_HOLD  = 1'b1;

  logic [0:0]           state_q, state_d;
  wb_entry_t            entry_q, entry_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 wb_valid;
  logic                 retire;
  logic                 capture;
  logic                 rd_live;
  logic [XLEN-1:0]      aligned_load;

  assign wb_valid = (state_q == STATE_HOLD);
  // A held CSR write blocks retirement (and therefore the RF write) until accepted.
  assign retire   = wb_valid && (!entry_q.flags.csr_write || csr_wready);
  assign mw_ready = !wb_valid || retire;
  assign capture  = mw_valid && mw_ready;
  assign rd_live  = wb_valid && entry_q.flags.reg_write && (entry_q.rd != 5'd0);

  core_wb_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .word   (entry_q.mem_data),
    .offset (entry_q.reg_data[1:0]),
    .mem_op (entry_q.mem_op),
    .result (aligned_load)
  );

  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, retire};
    if (capture) begin
      state_d                     = STATE_HOLD;
      entry_d.rd                  = mw_rd;
      entry_d.reg_data            = mw_reg_data;
      entry_d.mem_data            = mw_mem_data;
      entry_d.csr_data            = mw_csr_data;
      entry_d.csr                 = mw_csr;
      entry_d.mem_op              = mw_mem_op;
      entry_d.flags.reg_write     = mw_reg_write;
      entry_d.flags.reg_write_sel = mw_reg_write_sel;
      entry_d.flags.csr_write     = mw_csr_write;
    end else if (retire) begin
      state_d = STATE_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q   <= STATE_EMPTY;
      entry_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      instret_q <= instret_d;
    end
  end

  assign rf_we     = rd_live && retire;
  assign rf_waddr  = entry_q.rd;
  assign rf_wdata  = entry_q.flags.reg_write_sel ? aligned_load : entry_q.reg_data;
  assign csr_we    = wb_valid && entry_q.flags.csr_write;
  assign csr_waddr = entry_q.csr;
  assign csr_wdata = entry_q.csr_data;
  assign fwd_valid = rd_live;
  assign fwd_rd    = entry_q.rd;
  assign fwd_data  = rf_wdata;
  assign instret   = instret_q;

endmodule

// File: tb/tb_core_wb.sv
// Self-checking bench for core_wb: fixed load/ALU vectors, CSR stall, back-to-back
// and reset corner sequences, then randomized traffic against a behavioural model.
module tb_core_wb;

  logic        clk;
  logic        rest;
  logic        mw_valid;
  logic        mw_ready;
  logic [31:0] mw_reg_data;
  logic [31:0] mw_mem_data;
  logic [31:0] mw_csr_data;
  logic [4:0]  mw_rd;
  logic        mw_reg_write;
  logic        mw_reg_write_sel;
  logic [2:0]  mw_mem_op;
  logic [11:0] mw_csr;
  logic        mw_csr_write;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_wready;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [63:0] instret;

  int nVectors = 0;
  int nMiscompares = 0;

  // Behavioural model of the held instruction: only what is architecturally visible.
  logic        mValid;
  logic        mRegWrite;
  logic        mCsrWrite;
  logic [4:0]  mRd;
  logic [31:0] mValue;
  logic [11:0] mCsr;
  logic [31:0] mCsrData;
  logic [63:0] mInstret;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] regData;
    logic [31:0] memData;
    logic [2:0]  memOp;
    logic        sel;
    logic        regWrite;
    logic [31:0] expData;
    logic        expWe;
  } vec_t;

  vec_t vecs[9];

  core_wb #(
    .INSTRET_W(64),
    .XLEN(32)
  ) dut (
    .clk              (clk),
    .rest             (rest),
    .mw_valid         (mw_valid),
    .mw_ready         (mw_ready),
    .mw_reg_data      (mw_reg_data),
    .mw_mem_data      (mw_mem_data),
    .mw_csr_data      (mw_csr_data),
    .mw_rd            (mw_rd),
    .mw_reg_write     (mw_reg_write),
    .mw_reg_write_sel (mw_reg_write_sel),
    .mw_mem_op        (mw_mem_op),
    .mw_csr           (mw_csr),
    .mw_csr_write     (mw_csr_write),
    .rf_we            (rf_we),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .csr_we           (csr_we),
    .csr_waddr        (csr_waddr),
    .csr_wdata        (csr_wdata),
    .csr_wready       (csr_wready),
    .fwd_valid        (fwd_valid),
    .fwd_rd           (fwd_rd),
    .fwd_data         (fwd_data),
    .instret          (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Load result from plain shift/mask arithmetic on the word and byte address.
  function automatic logic [31:0] refLoad(input logic [31:0] word, input logic [31:0] addr,
                                          input logic [2:0] op, input logic sel);
    int unsigned off;
    int unsigned b;
    int unsigned h;
    if (!sel) return addr;
    off = addr % 4;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * (off / 2))) & 32'hFFFF;
    case (op)
      3'd0:    return (b >= 128) ? 32'(b + 32'hFFFF_FF00) : 32'(b);
      3'd4:    return 32'(b);
      3'd1:    return (h >= 32768) ? 32'(h + 32'hFFFF_0000) : 32'(h);
      3'd5:    return 32'(h);
      default: return word;
    endcase
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    logic canRetire;
    logic live;
    canRetire = mValid && (!mCsrWrite || csr_wready);
    live      = mValid && mRegWrite && (mRd != 5'd0);
    cmp("mw_ready", mw_ready, !mValid || canRetire);
    cmp("rf_we", rf_we, live && canRetire);
    cmp("rf_waddr", rf_waddr, mRd);
    cmp("rf_wdata", rf_wdata, mValue);
    cmp("csr_we", csr_we, mValid && mCsrWrite);
    cmp("csr_waddr", csr_waddr, mCsr);
    cmp("csr_wdata", csr_wdata, mCsrData);
    cmp("fwd_valid", fwd_valid, live);
    cmp("fwd_rd", fwd_rd, mRd);
    cmp("fwd_data", fwd_data, mValue);
    cmp("instret", instret, mInstret);
  endtask

  task automatic modelUpdate();
    logic canRetire;
    if (rest) begin
      mValid = 0; mRegWrite = 0; mCsrWrite = 0; mRd = 0;
      mValue = 0; mCsr = 0; mCsrData = 0; mInstret = 0;
      return;
    end
    canRetire = mValid && (!mCsrWrite || csr_wready);
    if (canRetire) mInstret = mInstret + 1;
    if (mw_valid && (!mValid || canRetire)) begin
      mValid    = 1;
      mRegWrite = mw_reg_write;
      mCsrWrite = mw_csr_write;
      mRd       = mw_rd;
      mValue    = refLoad(mw_mem_data, mw_reg_data, mw_mem_op, mw_reg_write_sel);
      mCsr      = mw_csr;
      mCsrData  = mw_csr_data;
    end else if (canRetire) begin
      mValid = 0;
    end
  endtask

  // One clock: check against the model, then advance DUT and model together.
  task automatic applyStimulus();
    #1;
    checkOutput();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  task automatic setEntry(input logic [4:0] rd, input logic [31:0] regData, input logic [31:0] memData,
                          input logic [2:0] memOp, input logic sel, input logic regWrite,
                          input logic csrWrite, input logic [11:0] csr, input logic [31:0] csrData);
    mw_valid = 1; mw_rd = rd; mw_reg_data = regData; mw_mem_data = memData;
    mw_mem_op = memOp; mw_reg_write_sel = sel; mw_reg_write = regWrite;
    mw_csr_write = csrWrite; mw_csr = csr; mw_csr_data = csrData;
  endtask

  task automatic setIdle();
    mw_valid = 0; mw_rd = 0; mw_reg_data = 0; mw_mem_data = 0; mw_mem_op = 0;
    mw_reg_write_sel = 0; mw_reg_write = 0; mw_csr_write = 0; mw_csr = 0; mw_csr_data = 0;
    csr_wready = 1;
  endtask

  initial begin
    logic [63:0] baseInstret;

    vecs[0] = '{5'd5, 32'h1234_5678, 32'h0,         3'b010, 1'b0, 1'b1, 32'h1234_5678, 1'b1};
    vecs[1] = '{5'd6, 32'h0000_1003, 32'h80FF_7F01, 3'b000, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b1};
    vecs[2] = '{5'd7, 32'h0000_1002, 32'h80FF_7F01, 3'b100, 1'b1, 1'b1, 32'h0000_00FF, 1'b1};
    vecs[3] = '{5'd8, 32'h0000_1002, 32'h80FF_7F01, 3'b001, 1'b1, 1'b1, 32'hFFFF_80FF, 1'b1};
    vecs[4] = '{5'd9, 32'h0000_1000, 32'h80FF_7F01, 3'b101, 1'b1, 1'b1, 32'h0000_7F01, 1'b1};
    vecs[5] = '{5'd10, 32'h0000_1000, 32'h80FF_7F01, 3'b010, 1'b1, 1'b1, 32'h80FF_7F01, 1'b1};
    vecs[6] = '{5'd0, 32'hDEAD_0000, 32'h0,         3'b010, 1'b0, 1'b1, 32'hDEAD_0000, 1'b0};
    vecs[7] = '{5'd11, 32'h0000_1003, 32'h80FF_7F01, 3'b001, 1'b1, 1'b1, 32'hFFFF_80FF, 1'b1};
    vecs[8] = '{5'd12, 32'h0000_1001, 32'h80FF_7F01, 3'b111, 1'b1, 1'b1, 32'h80FF_7F01, 1'b1};

    setIdle();
    rest = 1;
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
    applyStimulus();
    rest = 0;
    #1;
    cmp("reset mw_ready", mw_ready, 1);
    cmp("reset csr_we", csr_we, 0);
    cmp("reset rf_wdata", rf_wdata, 0);
    cmp("reset instret", instret, 0);
    applyStimulus();

    for (int i = 0; i < 9; i++) begin
      setEntry(vecs[i].rd, vecs[i].regData, vecs[i].memData, vecs[i].memOp,
               vecs[i].sel, vecs[i].regWrite, 1'b0, 12'h0, 32'h0);
      applyStimulus();
      setIdle();
      #1;
      cmp($sformatf("tbl%0d rf_we", i), rf_we, vecs[i].expWe);
      cmp($sformatf("tbl%0d rf_wdata", i), rf_wdata, vecs[i].expData);
      cmp($sformatf("tbl%0d fwd_valid", i), fwd_valid, vecs[i].expWe);
      applyStimulus();
    end
    cmp("tbl instret", instret, 64'd9);

    // CSR write stalled for three cycles while upstream keeps offering an entry.
    setEntry(5'd7, 32'h55, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 12'h300, 32'h8);
    applyStimulus();
    setEntry(5'd3, 32'hAA, 32'h0, 3'b010, 1'b0, 1'b1, 1'b0, 12'h0, 32'h0);
    csr_wready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      cmp("stall csr_we", csr_we, 1);
      cmp("stall csr_waddr", csr_waddr, 12'h300);
      cmp("stall csr_wdata", csr_wdata, 32'h8);
      cmp("stall mw_ready", mw_ready, 0);
      cmp("stall rf_we", rf_we, 0);
      cmp("stall fwd_valid", fwd_valid, 1);
      applyStimulus();
    end
    setIdle();
    #1;
    cmp("release rf_we", rf_we, 1);
    cmp("release csr_we", csr_we, 1);
    cmp("release mw_ready", mw_ready, 1);
    cmp("release rf_waddr", rf_waddr, 5'd7);
    applyStimulus();
    applyStimulus();

    // Back-to-back entries: one retire per cycle, never back-pressured.
    baseInstret = mInstret;
    for (int i = 0; i < 4; i++) begin
      setEntry(5'(i + 1), 32'(i * 4), 32'h0, 3'b010, 1'b0, 1'b1, 1'b0, 12'h0, 32'h0);
      #1;
      cmp("b2b mw_ready", mw_ready, 1);
      applyStimulus();
    end
    setIdle();
    applyStimulus();
    applyStimulus();
    cmp("b2b instret", instret, baseInstret + 64'd4);

    // Reset while a CSR write is stalled drops the entry.
    setEntry(5'd9, 32'h77, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 12'h341, 32'h1);
    applyStimulus();
    setIdle();
    csr_wready = 0;
    applyStimulus();
    rest = 1;
    applyStimulus();
    rest = 0;
    #1;
    cmp("rst-stall csr_we", csr_we, 0);
    cmp("rst-stall fwd_valid", fwd_valid, 0);
    cmp("rst-stall instret", instret, 0);
    cmp("rst-stall mw_ready", mw_ready, 1);
    applyStimulus();

    for (int i = 0; i < 400; i++) begin
      setEntry(($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom, $urandom,
               3'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
               12'($urandom), $urandom);
      mw_valid   = ($urandom_range(0, 3) != 0);
      csr_wready = ($urandom_range(0, 2) != 0);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
